// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, idle/initial
// column and row patterns, and the helpers that turn a row/column hit into a hex code.
package keypad_pkg;

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;

  localparam logic [3:0] COL_INIT  = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Physical keypad legend, indexed as {row, column}.
  function automatic logic [3:0] keyMap(input logic [1:0] rowIdx, input logic [1:0] colIdx);
    logic [3:0] code;
    case ({rowIdx, colIdx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row wins when several rows are pulled down together.
  function automatic logic [1:0] firstLowRow(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines; idles high
// (no key) out of reset.
module row_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_i,
  output logic [3:0] rs_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= ROWS_IDLE;
      sync_q <= ROWS_IDLE;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign rs_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces the row
// pattern seen on it, and reports accepted presses as a hex code plus a valid pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL_CYCLES     = 50000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DWELL_CYCLES);
  localparam int SW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CW-1:0] DWELL_LAST     = CW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0] SAMPLES_NEEDED = SW'(DEBOUNCE_SAMPLES);

  logic [3:0]    rs;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] dwellCnt_q, dwellCnt_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    pat_q, pat_d;
  logic [SW-1:0] stableCnt_q, stableCnt_d;
  logic [SW-1:0] relCnt_q, relCnt_d;
  logic [3:0]    keyCode_q, keyCode_d;
  logic          keyValid_q, keyValid_d;
  logic          keyHeld_q, keyHeld_d;

  logic          tc;
  logic          accept;
  logic [3:0]    colRot;
  logic [1:0]    colIdx;
  logic [SW-1:0] stableNext;
  logic [SW-1:0] relNext;

  row_sync u_row_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .row_i  (row),
    .rs_o   (rs)
  );

  assign tc         = (dwellCnt_q == DWELL_LAST);
  assign colRot     = {col_q[2:0], col_q[3]};
  assign stableNext = (stableCnt_q >= SAMPLES_NEEDED) ? stableCnt_q : stableCnt_q + SW'(1);
  assign relNext    = (relCnt_q >= SAMPLES_NEEDED) ? relCnt_q : relCnt_q + SW'(1);

  always_comb begin
    case (col_q)
      4'b1101: colIdx = 2'd1;
      4'b1011: colIdx = 2'd2;
      4'b0111: colIdx = 2'd3;
      default: colIdx = 2'd0;
    endcase
  end

  // Columns only move on tc, so wrapping at tc also restarts the dwell on every column change.
  always_comb begin
    state_d     = state_q;
    dwellCnt_d  = tc ? '0 : dwellCnt_q + CW'(1);
    col_d       = col_q;
    pat_d       = pat_q;
    stableCnt_d = stableCnt_q;
    relCnt_d    = relCnt_q;
    keyCode_d   = keyCode_q;
    keyValid_d  = 1'b0;
    keyHeld_d   = keyHeld_q;
    accept      = 1'b0;

    if (tc) begin
      case (state_q)
        SCAN: begin
          if (rs != ROWS_IDLE) begin
            pat_d       = rs;
            stableCnt_d = SW'(1);
            if (DEBOUNCE_SAMPLES <= 1) accept = 1'b1;
            else state_d = DEBOUNCE;
          end else begin
            col_d = colRot;
          end
        end
        DEBOUNCE: begin
          if (rs == pat_q) begin
            stableCnt_d = stableNext;
            if (stableNext == SAMPLES_NEEDED) accept = 1'b1;
          end else begin
            col_d   = colRot;
            state_d = SCAN;
          end
        end
        PRESSED: begin
          if (rs == ROWS_IDLE) begin
            relCnt_d = relNext;
            if (relNext == SAMPLES_NEEDED) begin
              keyHeld_d = 1'b0;
              col_d     = colRot;
              state_d   = SCAN;
            end
          end else begin
            relCnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    // On acceptance rs equals the captured pattern, so it can be decoded directly.
    if (accept) begin
      keyCode_d  = keyMap(firstLowRow(rs), colIdx);
      keyValid_d = 1'b1;
      keyHeld_d  = 1'b1;
      relCnt_d   = '0;
      state_d    = PRESSED;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCAN;
      dwellCnt_q  <= '0;
      col_q       <= COL_INIT;
      pat_q       <= ROWS_IDLE;
      stableCnt_q <= '0;
      relCnt_q    <= '0;
      keyCode_q   <= 4'h0;
      keyValid_q  <= 1'b0;
      keyHeld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwellCnt_q  <= dwellCnt_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      stableCnt_q <= stableCnt_d;
      relCnt_q    <= relCnt_d;
      keyCode_q   <= keyCode_d;
      keyValid_q  <= keyValid_d;
      keyHeld_q   <= keyHeld_d;
    end
  end

  assign col       = col_q;
  assign key_code  = keyCode_q;
  assign key_valid = keyValid_q;
  assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a model keypad (pressed-key matrix wired through the
// driven column) plus timing expectations computed from dwell/debounce arithmetic.
module tb_keypad_scanner;

  localparam int DWELL = 4;
  localparam int DEB   = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0] pressed [4];
  logic       overrideEn;
  logic [3:0] overrideRow;

  logic [3:0] keyTab [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'h0, 4'hF, 4'hE, 4'hD}};

  int cyc;
  int passCnt;
  int totalCnt;

  always #5 clk = ~clk;

  keypad_scanner #(.DWELL_CYCLES(DWELL), .DEBOUNCE_SAMPLES(DEB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // A pressed key shorts its row to its column; a row reads low when its key's column is driven low.
  always_comb begin
    row = 4'b1111;
    if (overrideEn) begin
      row = overrideRow;
    end else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (pressed[r][c] && !col[c]) row[r] = 1'b0;
    end
  end

  function automatic logic [3:0] expColAt(input int i);
    logic [3:0] oneHot;
    oneHot = 4'b0001 << ((i / DWELL) % 4);
    return ~oneHot;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic clearKeys();
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
    overrideEn  = 1'b0;
    overrideRow = 4'b1111;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    clearKeys();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    doReset();
    pressed[2][0] = 1'b1;
    repeat (11) tick();
    #2 reset_n = 1'b0;
    #1;
    totalCnt++;
    if ({col, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0})
      $display("[TB] FAIL reset_async: got col=%b code=%h valid=%b held=%b expected col=1110 code=0 valid=0 held=0",
               col, key_code, key_valid, key_held);
    else passCnt++;
    clearKeys();
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    for (int i = 0; i <= DWELL; i++) begin
      totalCnt++;
      if (col !== expColAt(cyc))
        $display("[TB] FAIL reset_release_col cyc=%0d: got %b expected %b", cyc, col, expColAt(cyc));
      else passCnt++;
      tick();
    end
  endtask

  task automatic test_scan();
    doReset();
    for (int i = 0; i < 5 * 4 * DWELL; i++) begin
      totalCnt++;
      if ({col, key_valid} !== {expColAt(cyc), 1'b0})
        $display("[TB] FAIL scan_idle cyc=%0d: got col=%b valid=%b expected col=%b valid=0",
                 cyc, col, key_valid, expColAt(cyc));
      else passCnt++;
      tick();
    end
  endtask

  task automatic test_press_release();
    int pulses, pulseCyc, relStart, firstIdleTc, fallCyc;
    logic [3:0] pulseCode;
    int expValidCyc;
    doReset();
    pressed[1][1] = 1'b1;
    expValidCyc = 1 * DWELL + DWELL - 1 + (DEB - 1) * DWELL + 1;
    pulses = 0; pulseCyc = -1; pulseCode = 4'hx;
    while (cyc < 200) begin
      if (key_valid === 1'b1) begin
        pulses++;
        pulseCyc  = cyc;
        pulseCode = key_code;
      end
      tick();
    end
    totalCnt++;
    if (pulses !== 1) $display("[TB] FAIL press_pulse_count: got %0d expected 1", pulses);
    else passCnt++;
    totalCnt++;
    if (pulseCyc !== expValidCyc) $display("[TB] FAIL press_latency: got cyc %0d expected cyc %0d", pulseCyc, expValidCyc);
    else passCnt++;
    totalCnt++;
    if ({pulseCode, key_held, col} !== {keyTab[1][1], 1'b1, 4'b1101})
      $display("[TB] FAIL press_state: got code=%h held=%b col=%b expected code=%h held=1 col=1101",
               pulseCode, key_held, col, keyTab[1][1]);
    else passCnt++;

    relStart = cyc;
    pressed[1][1] = 1'b0;
    firstIdleTc = relStart + 2;
    while (firstIdleTc % DWELL != DWELL - 1) firstIdleTc++;
    fallCyc = firstIdleTc + (DEB - 1) * DWELL + 1;
    while (cyc <= fallCyc + DWELL) begin
      if (cyc == fallCyc - 1) begin
        totalCnt++;
        if ({key_held, col} !== {1'b1, 4'b1101})
          $display("[TB] FAIL release_before: got held=%b col=%b expected held=1 col=1101", key_held, col);
        else passCnt++;
      end
      if (cyc == fallCyc) begin
        totalCnt++;
        if ({key_held, col, key_code} !== {1'b0, 4'b1011, 4'h5})
          $display("[TB] FAIL release_fall: got held=%b col=%b code=%h expected held=0 col=1011 code=5",
                   key_held, col, key_code);
        else passCnt++;
      end
      if (cyc == fallCyc + DWELL) begin
        totalCnt++;
        if (col !== 4'b0111) $display("[TB] FAIL release_rescan: got col=%b expected 0111", col);
        else passCnt++;
      end
      tick();
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    logic [3:0] expCol;
    doReset();
    pat = 4'($urandom_range(0, 14));
    overrideEn = 1'b1;
    for (int i = 0; i < 5 * DWELL; i++) begin
      overrideRow = (cyc <= DWELL - 1) ? pat : 4'b1111;
      expCol = (cyc < 2 * DWELL) ? 4'b1110 : expColAt(cyc - DWELL);
      totalCnt++;
      if ({col, key_valid} !== {expCol, 1'b0})
        $display("[TB] FAIL bounce pat=%b cyc=%0d: got col=%b valid=%b expected col=%b valid=0",
                 pat, cyc, col, key_valid, expCol);
      else passCnt++;
      tick();
    end
  endtask

  task automatic test_keys(input int c, input logic [3:0] rowPat, input bit resetAfter);
    int lowest, pulses, pulseCyc, expValidCyc;
    logic [3:0] pulseCode;
    logic [3:0] colLow;
    doReset();
    lowest = -1;
    for (int r = 0; r < 4; r++) begin
      if (!rowPat[r]) begin
        pressed[r][c] = 1'b1;
        if (lowest < 0) lowest = r;
      end
    end
    colLow = 4'b0001 << c;
    colLow = ~colLow;
    expValidCyc = c * DWELL + DWELL - 1 + (DEB - 1) * DWELL + 1;
    pulses = 0; pulseCyc = -1; pulseCode = 4'hx;
    while (cyc < expValidCyc + 3 * DWELL) begin
      if (key_valid === 1'b1) begin
        pulses++;
        pulseCyc  = cyc;
        pulseCode = key_code;
      end
      tick();
    end
    totalCnt++;
    if ({pulses, pulseCyc} !== {1, expValidCyc})
      $display("[TB] FAIL key_pulse c=%0d rows=%b: got %0d pulses at cyc %0d expected 1 at cyc %0d",
               c, rowPat, pulses, pulseCyc, expValidCyc);
    else passCnt++;
    totalCnt++;
    if ({pulseCode, key_held, col} !== {keyTab[lowest][c], 1'b1, colLow})
      $display("[TB] FAIL key_code c=%0d rows=%b: got code=%h held=%b col=%b expected code=%h held=1 col=%b",
               c, rowPat, pulseCode, key_held, col, keyTab[lowest][c], colLow);
    else passCnt++;
    if (resetAfter) begin
      #2 reset_n = 1'b0;
      #1;
      totalCnt++;
      if ({key_held, col, key_code, key_valid} !== {1'b0, 4'b1110, 4'h0, 1'b0})
        $display("[TB] FAIL reset_pressed: got held=%b col=%b code=%h valid=%b expected held=0 col=1110 code=0 valid=0",
                 key_held, col, key_code, key_valid);
      else passCnt++;
      @(negedge clk);
      reset_n = 1'b1;
      cyc = 0;
    end
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 8; n++)
      test_keys(int'($urandom_range(0, 3)), 4'($urandom_range(0, 14)), 1'b0);
  endtask

  initial begin
    passCnt  = 0;
    totalCnt = 0;
    cyc      = 0;
    clearKeys();
    test_reset();
    test_scan();
    test_press_release();
    test_bounce();
    test_bounce();
    test_keys(3, 4'b0111, 1'b0);
    test_keys(0, 4'b0101, 1'b0);
    test_random_keys();
    test_keys(2, 4'b1011, 1'b1);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
